// File: rtl/ghost_pkg.sv
// Shared definitions for the ghost movers and the catch monitor:
// state encoding, coordinate widths and movement direction codes.
package ghost_pkg;

   localparam int X_W   = 10;
   localparam int Y_W   = 9;
   localparam int CNT_W = 8;

   typedef enum logic [2:0] {
      PLAY      = 3'd0,
      FREEZE    = 3'd1,
      RESPAWN   = 3'd2,
      GRACE     = 3'd3,
      GAME_OVER = 3'd4
   } catch_state_t;

   typedef enum logic [1:0] {
      DIR_UP    = 2'b00,
      DIR_DOWN  = 2'b01,
      DIR_LEFT  = 2'b10,
      DIR_RIGHT = 2'b11
   } dir_t;

endpackage

// File: rtl/box_overlap.sv
// Combinational square-box proximity test between two sprite positions.
// Also intended for pellet pickup, so it carries no game state.
module box_overlap
   import ghost_pkg::*;
#(
   parameter int HIT_R = 8
) (
   input  logic [X_W-1:0] a_x,
   input  logic [Y_W-1:0] a_y,
   input  logic [X_W-1:0] b_x,
   input  logic [Y_W-1:0] b_y,
   output logic           hit
);

   localparam logic [X_W:0] HIT_X = (X_W+1)'(HIT_R);
   localparam logic [Y_W:0] HIT_Y = (Y_W+1)'(HIT_R);

   logic signed [X_W:0] dx;
   logic signed [Y_W:0] dy;
   logic [X_W:0] abs_dx;
   logic [Y_W:0] abs_dy;

   // Zero-extend before subtracting so far-apart positions cannot wrap into a near miss.
   assign dx = $signed({1'b0, a_x}) - $signed({1'b0, b_x});
   assign dy = $signed({1'b0, a_y}) - $signed({1'b0, b_y});

   assign abs_dx = dx[X_W] ? $unsigned(-dx) : $unsigned(dx);
   assign abs_dy = dy[Y_W] ? $unsigned(-dy) : $unsigned(dy);

   assign hit = (abs_dx < HIT_X) && (abs_dy < HIT_Y);

endmodule

// File: rtl/ghost_catch_monitor.sv
// Detects Pac-Man being caught on movement ticks, then sequences freeze,
// respawn handshake and grace window, and tracks remaining lives.
module ghost_catch_monitor
   import ghost_pkg::*;
#(
   parameter int HIT_R        = 8,
   parameter int LIVES_INIT   = 3,
   parameter int FREEZE_TICKS = 64,
   parameter int GRACE_TICKS  = 128
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           tick,
   input  logic           start,
   input  logic [X_W-1:0] pac_x,
   input  logic [Y_W-1:0] pac_y,
   input  logic [X_W-1:0] ghost_x,
   input  logic [Y_W-1:0] ghost_y,
   input  logic           respawn_ack,
   output logic           caught,
   output logic           freeze,
   output logic           respawn_req,
   output logic [1:0]     lives,
   output logic           grace,
   output logic           game_over
);

   localparam logic [CNT_W-1:0] FREEZE_LAST = CNT_W'(FREEZE_TICKS - 1);
   localparam logic [CNT_W-1:0] GRACE_LAST  = CNT_W'(GRACE_TICKS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [1:0]       LIVES_RST   = 2'(LIVES_INIT);

   catch_state_t     state, state_next;
   logic [1:0]       lives_next;
   logic [CNT_W-1:0] tick_cnt, cnt_next;
   logic             caught_next;
   logic             hit;

   box_overlap #(.HIT_R(HIT_R)) u_overlap (
      .a_x (pac_x),
      .a_y (pac_y),
      .b_x (ghost_x),
      .b_y (ghost_y),
      .hit (hit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= PLAY;
         lives    <= LIVES_RST;
         tick_cnt <= '0;
         caught   <= 1'b0;
      end else begin
         state    <= state_next;
         lives    <= lives_next;
         tick_cnt <= cnt_next;
         caught   <= caught_next;
      end
   end

   always_comb begin
      state_next  = state;
      lives_next  = lives;
      cnt_next    = tick_cnt;
      caught_next = 1'b0;
      unique case (state)
         PLAY: begin
            if (tick && hit) begin
               caught_next = 1'b1;
               cnt_next    = '0;
               if (lives <= 2'd1) begin
                  lives_next = 2'd0;
                  state_next = GAME_OVER;
               end else begin
                  lives_next = lives - 2'd1;
                  state_next = FREEZE;
               end
            end
         end
         FREEZE: begin
            if (tick) begin
               if (tick_cnt == FREEZE_LAST) state_next = RESPAWN;
               else if (tick_cnt != CNT_MAX) cnt_next = tick_cnt + 1'b1;
            end
         end
         // A tick coinciding with the ack is dropped: the grace count restarts from zero.
         RESPAWN: begin
            if (respawn_ack) begin
               state_next = GRACE;
               cnt_next   = '0;
            end
         end
         GRACE: begin
            if (tick) begin
               if (tick_cnt == GRACE_LAST) state_next = PLAY;
               else if (tick_cnt != CNT_MAX) cnt_next = tick_cnt + 1'b1;
            end
         end
         GAME_OVER: begin
            if (start) begin
               lives_next = LIVES_RST;
               state_next = RESPAWN;
            end
         end
         default: state_next = PLAY;
      endcase
   end

   always_comb begin
      freeze      = 1'b0;
      respawn_req = 1'b0;
      grace       = 1'b0;
      game_over   = 1'b0;
      unique case (state)
         FREEZE:    freeze = 1'b1;
         RESPAWN: begin
            freeze      = 1'b1;
            respawn_req = 1'b1;
         end
         GRACE:     grace = 1'b1;
         GAME_OVER: begin
            freeze    = 1'b1;
            game_over = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ghost_catch_monitor.sv
// Directed bench for ghost_catch_monitor: catches, freeze/respawn/grace timing,
// lives and game over, restart, reset mid-freeze and coordinate sign handling.
module tb_ghost_catch_monitor;

   logic       clk = 1'b0;
   logic       rst, tick, start, respawn_ack;
   logic [9:0] pac_x, ghost_x;
   logic [8:0] pac_y, ghost_y;
   logic       caught, freeze, respawn_req, grace, game_over;
   logic [1:0] lives;

   int errors = 0;
   int checks = 0;
   int seen;

   ghost_catch_monitor dut (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .start       (start),
      .pac_x       (pac_x),
      .pac_y       (pac_y),
      .ghost_x     (ghost_x),
      .ghost_y     (ghost_y),
      .respawn_ack (respawn_ack),
      .caught      (caught),
      .freeze      (freeze),
      .respawn_req (respawn_req),
      .lives       (lives),
      .grace       (grace),
      .game_over   (game_over)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic checkFlags(input string tag, input int c, input int f, input int r,
                             input int g, input int go);
      checkOutput({tag, ".caught"},      int'(caught),      c);
      checkOutput({tag, ".freeze"},      int'(freeze),      f);
      checkOutput({tag, ".respawn_req"}, int'(respawn_req), r);
      checkOutput({tag, ".grace"},       int'(grace),       g);
      checkOutput({tag, ".game_over"},   int'(game_over),   go);
   endtask

   task automatic applyStimulus(input logic [9:0] px, input logic [8:0] py,
                                input logic [9:0] gx, input logic [8:0] gy);
      pac_x   = px;
      pac_y   = py;
      ghost_x = gx;
      ghost_y = gy;
   endtask

   // Called at a falling edge; returns at the next falling edge with outputs settled.
   task automatic pulseTick();
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic tickMany(input int n, output int hits);
      hits = 0;
      repeat (n) begin
         pulseTick();
         hits += int'(caught);
      end
   endtask

   initial begin
      rst = 1'b1;
      tick = 1'b0;
      start = 1'b0;
      respawn_ack = 1'b0;
      applyStimulus(10'd200, 9'd146, 10'd208, 9'd146);
      @(negedge clk);
      @(negedge clk);
      checkOutput("reset.lives", int'(lives), 3);
      checkFlags("reset", 0, 0, 0, 0, 0);
      rst = 1'b0;

      pulseTick();
      checkOutput("miss_dx8.caught", int'(caught), 0);
      checkOutput("miss_dx8.lives", int'(lives), 3);

      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkFlags("start_in_play", 0, 0, 0, 0, 0);
      checkOutput("start_in_play.lives", int'(lives), 3);

      applyStimulus(10'd0, 9'd146, 10'd1020, 9'd146);
      pulseTick();
      checkOutput("far_x_sign.caught", int'(caught), 0);

      applyStimulus(10'd200, 9'd146, 10'd205, 9'd150);
      seen = 0;
      repeat (1000) begin
         @(negedge clk);
         seen += int'(caught);
      end
      checkOutput("no_tick_overlap.caught_count", seen, 0);

      pulseTick();
      checkFlags("catch1", 1, 1, 0, 0, 0);
      checkOutput("catch1.lives", int'(lives), 2);
      @(negedge clk);
      checkFlags("catch1_after", 0, 1, 0, 0, 0);

      tickMany(63, seen);
      checkOutput("freeze63.caught_count", seen, 0);
      checkFlags("freeze63", 0, 1, 0, 0, 0);
      pulseTick();
      checkFlags("freeze64", 0, 1, 1, 0, 0);
      repeat (2) @(negedge clk);
      checkOutput("respawn_hold.respawn_req", int'(respawn_req), 1);
      respawn_ack = 1'b1;
      @(negedge clk);
      respawn_ack = 1'b0;
      checkFlags("ack1", 0, 0, 0, 1, 0);

      tickMany(127, seen);
      checkOutput("grace127.caught_count", seen, 0);
      checkOutput("grace127.grace", int'(grace), 1);
      checkOutput("grace127.lives", int'(lives), 2);
      pulseTick();
      checkFlags("grace128", 0, 0, 0, 0, 0);

      applyStimulus(10'd200, 9'd146, 10'd207, 9'd146);
      pulseTick();
      checkOutput("catch2_dx7.caught", int'(caught), 1);
      checkOutput("catch2_dx7.lives", int'(lives), 1);

      tickMany(63, seen);
      respawn_ack = 1'b1;
      pulseTick();
      checkFlags("respawn2_entry", 0, 1, 1, 0, 0);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      respawn_ack = 1'b0;
      checkFlags("ack2_early", 0, 0, 0, 1, 0);
      tickMany(127, seen);
      checkOutput("grace2_127.grace", int'(grace), 1);
      pulseTick();
      checkOutput("grace2_128.grace", int'(grace), 0);

      pulseTick();
      checkFlags("catch3", 1, 1, 0, 0, 1);
      checkOutput("catch3.lives", int'(lives), 0);
      @(negedge clk);
      checkOutput("catch3_after.caught", int'(caught), 0);
      tickMany(5, seen);
      checkOutput("gameover_ticks.caught_count", seen, 0);
      checkOutput("gameover_ticks.lives", int'(lives), 0);

      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkFlags("restart", 0, 1, 1, 0, 0);
      checkOutput("restart.lives", int'(lives), 3);

      respawn_ack = 1'b1;
      @(negedge clk);
      respawn_ack = 1'b0;
      checkOutput("restart_ack.grace", int'(grace), 1);
      tickMany(128, seen);
      checkFlags("restart_play", 0, 0, 0, 0, 0);

      pulseTick();
      checkOutput("catch4.lives", int'(lives), 2);
      tickMany(30, seen);
      checkFlags("freeze30", 0, 1, 0, 0, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkFlags("rst_mid_freeze", 0, 0, 0, 0, 0);
      checkOutput("rst_mid_freeze.lives", int'(lives), 3);
      pulseTick();
      checkOutput("post_rst_catch.caught", int'(caught), 1);
      checkOutput("post_rst_catch.lives", int'(lives), 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
